// File: rtl/home_sensor_scanner.sv
// Round-robin home sensor scanner: NUM_DIG digital slots plus one temperature slot,
// with dwell timing, masking, sticky acknowledgeable events and hysteresis climate control.
module home_sensor_scanner #(
    parameter int NUM_DIG   = 4,
    parameter int TEMP_W    = 7,
    parameter int T_LOW     = 50,
    parameter int T_HIGH    = 70,
    parameter int HYST      = 2,
    parameter int DWELL     = 1,
    parameter int CLIM_HOLD = 0,
    parameter int DISP_W    = 3,
    localparam int SLOT_W   = $clog2(NUM_DIG + 1)
) (
    input  logic               Clk,
    input  logic               Rst,
    input  logic [NUM_DIG-1:0] Sens,
    input  logic [NUM_DIG-1:0] Mask,
    input  logic [NUM_DIG-1:0] Ack,
    input  logic [TEMP_W-1:0]  ST,
    output logic [NUM_DIG-1:0] act,
    output logic               heater,
    output logic               cooler,
    output logic [NUM_DIG-1:0] evt,
    output logic               any_evt,
    output logic [DISP_W-1:0]  display,
    output logic [SLOT_W-1:0]  slot
);

    typedef enum logic [1:0] {
        CLIM_IDLE,
        CLIM_HEAT,
        CLIM_COOL
    } clim_t;

    localparam int DW_W = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [DW_W-1:0]   DWELL_LAST = DW_W'(DWELL - 1);
    localparam logic [SLOT_W-1:0] TEMP_SLOT  = SLOT_W'(NUM_DIG);
    localparam logic [TEMP_W:0]   HEAT_ON    = (TEMP_W + 1)'(T_LOW);
    localparam logic [TEMP_W:0]   COOL_ON    = (TEMP_W + 1)'(T_HIGH);
    localparam logic [TEMP_W:0]   HEAT_OFF   = (TEMP_W + 1)'(T_LOW + HYST);
    localparam logic [TEMP_W:0]   COOL_OFF   = (TEMP_W + 1)'(T_HIGH - HYST);

    logic [DW_W-1:0]    dwell_q, dwell_d;
    logic [SLOT_W-1:0]  slot_d;
    clim_t              clim_q, clim_d;
    logic [NUM_DIG-1:0] act_d, evt_d, evt_set;
    logic [DISP_W-1:0]  disp_d;
    logic               heat_q, heat_d, cool_q, cool_d;
    logic [TEMP_W:0]    st_x;

    assign st_x = {1'b0, ST};

    // NOTE: every signal gets a default before any branch so no latch is inferred.
    always_comb begin
        dwell_d = dwell_q;
        slot_d  = slot;
        clim_d  = clim_q;
        act_d   = act;
        disp_d  = display;
        heat_d  = heat_q;
        cool_d  = cool_q;
        evt_set = '0;

        if (dwell_q == DWELL_LAST) begin
            dwell_d = '0;
            slot_d  = (slot == TEMP_SLOT) ? '0 : slot + 1'b1;
        end else begin
            dwell_d = dwell_q + 1'b1;
        end

        // Inputs only matter on the first edge of a slot; results hold for the rest.
        if (dwell_q == '0) begin
            act_d  = '0;
            disp_d = '0;
            heat_d = 1'b0;
            cool_d = 1'b0;
            if (slot == TEMP_SLOT) begin
                unique case (clim_q)
                    CLIM_IDLE: begin
                        if (st_x < HEAT_ON)      clim_d = CLIM_HEAT;
                        else if (st_x > COOL_ON) clim_d = CLIM_COOL;
                    end
                    CLIM_HEAT: if (st_x >= HEAT_OFF) clim_d = CLIM_IDLE;
                    CLIM_COOL: if (st_x <= COOL_OFF) clim_d = CLIM_IDLE;
                    default:   clim_d = CLIM_IDLE;
                endcase
                heat_d = (clim_d == CLIM_HEAT);
                cool_d = (clim_d == CLIM_COOL);
                if (heat_d)      disp_d = DISP_W'(NUM_DIG + 1);
                else if (cool_d) disp_d = DISP_W'(NUM_DIG + 2);
            end else begin
                for (int i = 0; i < NUM_DIG; i++) begin
                    if (slot == SLOT_W'(i) && Sens[i] && !Mask[i]) begin
                        act_d[i]   = 1'b1;
                        evt_set[i] = 1'b1;
                        disp_d     = DISP_W'(i + 1);
                    end
                end
            end
        end

        // A new hit outranks an acknowledge on the same edge.
        evt_d = (evt & ~Ack) | evt_set;
    end

    // NOTE: sequential state uses non-blocking assignments so all registers see pre-edge values.
    always_ff @(negedge Clk) begin
        if (!Rst) begin
            dwell_q <= '0;
            slot    <= '0;
            clim_q  <= CLIM_IDLE;
            act     <= '0;
            display <= '0;
            heat_q  <= 1'b0;
            cool_q  <= 1'b0;
            evt     <= '0;
            any_evt <= 1'b0;
        end else begin
            dwell_q <= dwell_d;
            slot    <= slot_d;
            clim_q  <= clim_d;
            act     <= act_d;
            display <= disp_d;
            heat_q  <= heat_d;
            cool_q  <= cool_d;
            evt     <= evt_d;
            any_evt <= |evt_d;
        end
    end

    assign heater = (CLIM_HOLD != 0) ? (clim_q == CLIM_HEAT) : heat_q;
    assign cooler = (CLIM_HOLD != 0) ? (clim_q == CLIM_COOL) : cool_q;

endmodule
